sub16_pipelined: RTL and testbench
==================================

// Module: sub16_pipelined
// PURPOSE
//  4-stage pipelined 16-bit subtractor: diff = a - b - bin, computed 4 bits per
//  stage with the borrow registered between stages. Companion to the pipelined
//  16-bit adder for the datapath's subtract direction. Adds valid/ready
//  handshakes with per-stage bubble collapse and emits borrow/zero/overflow flags.
// PARAMETERS
//  WIDTH  16  operand/result width; must equal SLICE*STAGES
//  SLICE  4   bits resolved per pipeline stage
//  STAGES 4   pipeline depth (WIDTH/SLICE)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  in_valid   in   1      a/b/bin valid this cycle
//  in_ready   out  1      stage 1 can accept this cycle
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      diff/flags valid
//  out_ready  in   1      consumer takes result this cycle
//  diff       out  WIDTH  a - b - bin, mod 2^WIDTH
//  bout       out  1      borrow out; 1 iff unsigned a < b + bin
//  zero       out  1      diff == 0
//  ovf        out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
// BEHAVIOUR
//  - Reset (reset==0, async): all stage valid bits, data, borrow regs -> 0;
//    out_valid=0, diff=0, bout=0, zero=0, ovf=0. Released sync to clk.
//  - Stage s (1..STAGES) holds valid v[s], diff bits [s*SLICE-1:0], borrow out
//    of slice s-1, and the not-yet-consumed upper a/b bits.
//  - Stage 1 computes slice 0 from a,b,bin at capture; stage s>1 computes
//    slice s-1 from its held operands and held borrow of stage s-1.
//  - Enables: en[STAGES] = ~v[STAGES] | out_ready;
//    en[s] = ~v[s] | en[s+1]; in_ready = en[1]. Combinational, no a->ready paths
//    other than via out_ready.
//  - Stage registers load only when en[s]; else hold (data and valid).
//    v[1] <= in_valid when en[1]; v[s] <= v[s-1] when en[s].
//  - Bubble collapse: an empty stage accepts even if downstream is stalled.
//  - Latency: transfer accepted in cycle c (in_valid&in_ready) is presented
//    with out_valid=1 in cycle c+4 when no backpressure; throughput 1/cycle.
//  - Outputs driven directly from stage STAGES registers; zero/ovf/bout are
//    registered with diff, never combinational from inputs.
//  - Full pipe + out_ready=0: in_ready=0, all stages hold. Simultaneous
//    out_ready=1 and in_valid=1 on full pipe: pop and push same edge.
//  - Data under invalid stages is don't-care for consumers but must not toggle
//    out_valid. Results leave strictly in acceptance order; none lost/duped.
//  - bin is honoured only in slice 0; bout is borrow out of the MSB slice.
// TESTING
//  1 a=0x1234,b=0x0234,bin=0, out_ready=1 -> 4 cycles later diff=0x1000,
//    bout=0,zero=0,ovf=0, out_valid one cycle.
//  2 a=0x0000,b=0x0001,bin=0 -> diff=0xFFFF,bout=1,ovf=0; a=0x8000,b=0x0001
//    -> diff=0x7FFF,bout=0,ovf=1.
//  3 a=0x5555,b=0x5555,bin=1 -> diff=0xFFFF,bout=1; same with bin=0 ->
//    diff=0x0000,zero=1,bout=0.
//  4 6 back-to-back ops, out_ready=0 for cycles 3..8 -> in_ready falls after
//    4 held, all 6 results emerge in order, unique, correct once released.
//  5 1 op, 2-cycle gap, 1 op, out_ready=0 -> second op collapses into stage
//    behind first (in_ready stays 1); both exit on consecutive cycles.
//  6 reset=0 while 3 ops in flight -> out_valid=0 and all outputs 0
//    immediately (async); after release, nothing emerges until new input.

Source files
------------

// File: rtl/sub16_pipelined.sv
// Pipelined subtractor: diff = a - b - bin, resolved SLICE bits per stage with the
// borrow carried in registers; valid/ready handshake with per-stage bubble collapse.
module sub16_pipelined #(
  parameter int WIDTH  = 16,
  parameter int SLICE  = 4,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  logic             v_q    [1:STAGES];
  logic [WIDTH-1:0] diff_q [1:STAGES];
  logic             brw_q  [1:STAGES];
  logic [WIDTH-1:0] a_q    [1:STAGES-1];
  logic [WIDTH-1:0] b_q    [1:STAGES-1];
  logic             en_w   [1:STAGES+1];
  logic             zero_q;
  logic             ovf_q;

  // A stage may load when it is empty or when its occupant moves on this edge.
  assign en_w[STAGES+1] = out_ready;

  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_stage
      localparam int LO = (gi - 1) * SLICE;

      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic [WIDTH-1:0] src_diff;
      logic             src_bin;
      logic             src_v;
      logic [SLICE:0]   res;
      logic [WIDTH-1:0] diff_d;

      assign en_w[gi] = ~v_q[gi] | en_w[gi+1];

      if (gi == 1) begin : g_first
        assign src_a    = a;
        assign src_b    = b;
        assign src_diff = '0;
        assign src_bin  = bin;
        assign src_v    = in_valid;
      end else begin : g_mid
        assign src_a    = a_q[gi-1];
        assign src_b    = b_q[gi-1];
        assign src_diff = diff_q[gi-1];
        assign src_bin  = brw_q[gi-1];
        assign src_v    = v_q[gi-1];
      end

      // Extra MSB of the slice subtraction goes to 1 exactly when a borrow is needed.
      assign res = {1'b0, src_a[LO +: SLICE]} - {1'b0, src_b[LO +: SLICE]}
                 - {{SLICE{1'b0}}, src_bin};

      always_comb begin
        diff_d              = src_diff;
        diff_d[LO +: SLICE] = res[SLICE-1:0];
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          v_q[gi]    <= 1'b0;
          diff_q[gi] <= '0;
          brw_q[gi]  <= 1'b0;
        end else if (en_w[gi]) begin
          v_q[gi]    <= src_v;
          diff_q[gi] <= diff_d;
          brw_q[gi]  <= res[SLICE];
        end
      end

      if (gi < STAGES) begin : g_opnd
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            a_q[gi] <= '0;
            b_q[gi] <= '0;
          end else if (en_w[gi]) begin
            a_q[gi] <= src_a;
            b_q[gi] <= src_b;
          end
        end
      end else begin : g_flags
        logic zero_d;
        logic ovf_d;

        assign zero_d = (diff_d == '0);
        assign ovf_d  = (src_a[WIDTH-1] ^ src_b[WIDTH-1]) & (diff_d[WIDTH-1] ^ src_a[WIDTH-1]);

        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
          end else if (en_w[gi]) begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
          end
        end
      end
    end
  endgenerate

  assign in_ready  = en_w[1];
  assign out_valid = v_q[STAGES];
  assign diff      = diff_q[STAGES];
  assign bout      = brw_q[STAGES];
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub16_pipelined.sv
// Scoreboard bench for sub16_pipelined: directed steps, reference results queued
// on acceptance and compared in order on each output handshake.
module tb_sub16_pipelined;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        z;
    logic        ov;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        zero;
  logic        ovf;

  res_t exp_q[$];
  int   acc_q[$];
  int   pop_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pushes = 0;
  bit   lat_chk = 1'b0;

  always #5 clk = ~clk;

  sub16_pipelined dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .zero     (zero),
    .ovf      (ovf)
  );

  function automatic res_t model(logic [15:0] ma, logic [15:0] mb, logic mbin);
    res_t        r;
    logic [16:0] t;
    t    = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
    r.d  = t[15:0];
    r.bo = t[16];
    r.z  = (t[15:0] == 16'd0);
    r.ov = (ma[15] != mb[15]) && (t[15] != ma[15]);
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: monitor handshakes at the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    res_t e;
    int   ac;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        ac = acc_q.pop_front();
        $display("cycle %0d out diff=%h bout=%b zero=%b ovf=%b exp=%h/%b/%b/%b",
                 cyc, diff, bout, zero, ovf, e.d, e.bo, e.z, e.ov);
        chk("result", {13'd0, diff, bout, zero, ovf}, {13'd0, e});
        if (lat_chk) chk("latency", cyc - ac, 32'd4);
        pop_cyc.push_back(cyc);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(a, b, bin));
      acc_q.push_back(cyc);
      pushes++;
      $display("cycle %0d in a=%h b=%h bin=%b", cyc, a, b, bin);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(logic [15:0] ia, logic [15:0] ib, logic ibin);
    int p0;
    p0       = pushes;
    a        = ia;
    b        = ib;
    bin      = ibin;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && pushes == p0; k++) step();
    chk("issue_accepted", pushes - p0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) step();
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int n4;
    int stall_at;
    int p0;
    bit hold;
    int ps;

    reset     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("reset_outputs", {11'd0, out_valid, diff, bout, zero, ovf}, 32'd0);
    reset = 1'b1;
    step();

    // Basic result and 4-cycle latency, out_valid for a single cycle.
    lat_chk = 1'b1;
    issue(16'h1234, 16'h0234, 1'b0);
    drain();
    lat_chk = 1'b0;
    step();
    chk("single_valid_pulse", {31'd0, out_valid}, 32'd0);

    // Borrow, overflow and zero corners, back to back.
    issue(16'h0000, 16'h0001, 1'b0);
    issue(16'h8000, 16'h0001, 1'b0);
    issue(16'h5555, 16'h5555, 1'b1);
    issue(16'h5555, 16'h5555, 1'b0);
    issue(16'h7FFF, 16'hFFFF, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    // Backpressure: six ops, consumer stalled for steps 3..8.
    n4       = 0;
    stall_at = -1;
    hold     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      out_ready = !(i >= 3 && i <= 8);
      if (n4 < 6) begin
        if (!hold) begin
          a   = 16'($urandom);
          b   = 16'($urandom);
          bin = 1'($urandom);
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && !in_ready && stall_at < 0) stall_at = n4;
      p0 = pushes;
      step();
      if (pushes != p0) begin
        n4++;
        hold = 1'b0;
      end else begin
        hold = 1'b1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stall_after_four", stall_at, 32'd4);
    chk("all_six_accepted", n4, 32'd6);
    drain();

    // Bubble collapse behind a stalled head.
    out_ready = 1'b0;
    issue(16'hA5A5, 16'h0F0F, 1'b0);
    step();
    step();
    chk("collapse_in_ready", {31'd0, in_ready}, 32'd1);
    issue(16'h0100, 16'h0200, 1'b1);
    for (int k = 0; k < 4; k++) step();
    chk("head_held_valid", {31'd0, out_valid}, 32'd1);
    chk("two_in_flight", exp_q.size(), 32'd2);
    ps        = pop_cyc.size();
    out_ready = 1'b1;
    drain();
    chk("two_popped", pop_cyc.size() - ps, 32'd2);
    if (pop_cyc.size() - ps == 2) chk("consecutive_exit", pop_cyc[ps+1] - pop_cyc[ps], 32'd1);

    // Asynchronous reset with ops in flight.
    issue(16'h1111, 16'h0001, 1'b0);
    issue(16'h2222, 16'h0002, 1'b0);
    issue(16'h3333, 16'h0003, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {11'd0, out_valid, diff, bout, zero, ovf}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    step();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("no_ghost_output", {31'd0, out_valid}, 32'd0);
    end
    issue(16'h0042, 16'h0040, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
